// File: rtl/cpu_int_pkg.sv
// cpu_int_pkg: shared IRQ FSM encodings, reset-qualifier constants and the IRQ priority encoder
package cpu_int_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ARMED    = 2'b01,
    SERVICED = 2'b10
  } irq_state_t;
  localparam int RST_HOLD_DEF = 4;
  localparam int CNT_W = 8;
  function automatic logic [3:0] prio_enc(input logic [15:0] v);
    prio_enc = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) prio_enc = 4'(i);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with a per-bit reset value
module sync_2ff #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         a_rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_q;
  // two-stage capture, both stages reset to the inactive level
  always_ff @(posedge clk or negedge a_rst)
    if (!a_rst) {r_q, r_meta} <= {RST_VAL, RST_VAL};
    else {r_q, r_meta} <= {r_meta, d};
  assign q = r_q;
endmodule

// File: rtl/int_arbiter.sv
// int_arbiter: NMI edge capture, reset qualification, IRQ mask and priority FSM (INT_SYNC_EN adds input synchronizers)
module int_arbiter
  import cpu_int_pkg::*;
#(
  parameter int N_IRQ    = 4,
  parameter int RST_HOLD = RST_HOLD_DEF
) (
  input  logic                     clk,
  input  logic                     a_rst,
  input  logic                     nmi_n_pin,
  input  logic                     rst_n_pin,
  input  logic [N_IRQ-1:0]         irq_src,
  input  logic                     irq_mask_wr,
  input  logic [N_IRQ-1:0]         irq_mask_din,
  input  logic                     nmi_ack,
  input  logic                     irq_ack,
  output logic                     nmi,
  output logic                     irq,
  output logic                     rst,
  output logic [$clog2(N_IRQ)-1:0] irq_id,
  output logic [N_IRQ-1:0]         irq_mask,
  output logic [N_IRQ-1:0]         irq_pending
);
  localparam int IDW = $clog2(N_IRQ);
  logic             w_nmi_s;
  logic             w_rst_s;
  logic [N_IRQ-1:0] w_irq_s;
`ifdef INT_SYNC_EN
  logic [N_IRQ+1:0] w_sync;
  sync_2ff #(.W(N_IRQ + 2), .RST_VAL({2'b11, {N_IRQ{1'b0}}})) u_sync (
    .clk   (clk),
    .a_rst (a_rst),
    .d     ({nmi_n_pin, rst_n_pin, irq_src}),
    .q     (w_sync)
  );
  assign {w_nmi_s, w_rst_s, w_irq_s} = w_sync;
`else
  assign {w_nmi_s, w_rst_s, w_irq_s} = {nmi_n_pin, rst_n_pin, irq_src};
`endif
  logic             r_nmi_prev;
  logic             r_nmi_pend;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rst;
  logic [N_IRQ-1:0] r_mask;
  logic [N_IRQ-1:0] r_pend;
  irq_state_t       r_state;
  irq_state_t       w_state_nxt;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   w_id_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [N_IRQ-1:0] w_pend;
  assign w_cnt_nxt = w_rst_s ? '0 : r_cnt + {{(CNT_W - 1){1'b0}}, ~&r_cnt};
  assign w_pend    = w_irq_s & ~r_mask;
  // NMI falling-edge capture; a new edge beats a same-cycle ack, qualified reset beats both
  always_ff @(posedge clk or negedge a_rst)
    if (!a_rst) {r_nmi_prev, r_nmi_pend} <= 2'b10;
    else begin
      r_nmi_prev <= w_nmi_s;
      r_nmi_pend <= !r_rst && ((r_nmi_prev && !w_nmi_s) || (r_nmi_pend && !nmi_ack));
    end
  // saturating low-sample counter; reset request drops on the first high sample
  always_ff @(posedge clk or negedge a_rst)
    if (!a_rst) {r_cnt, r_rst} <= '0;
    else begin
      r_cnt <= w_cnt_nxt;
      r_rst <= !w_rst_s && (w_cnt_nxt >= CNT_W'(RST_HOLD));
    end
  // mask register, pending snapshot, FSM state and latched IRQ index
  always_ff @(posedge clk or negedge a_rst)
    if (!a_rst) begin
      r_mask  <= '1;
      r_pend  <= '0;
      r_state <= IDLE;
      r_id    <= '0;
    end else begin
      r_mask  <= irq_mask_wr ? irq_mask_din : r_mask;
      r_pend  <= w_pend;
      r_state <= w_state_nxt;
      r_id    <= w_id_nxt;
    end
  // IRQ FSM: arm on lowest pending index, hold it through service, drop on a vanished source
  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    if (r_rst) w_state_nxt = IDLE;
    else
      case (r_state)
        IDLE:
          if (|w_pend) begin
            w_state_nxt = ARMED;
            w_id_nxt    = IDW'(prio_enc(16'(w_pend)));
          end
        ARMED:    w_state_nxt = irq_ack ? SERVICED : (w_pend[r_id] ? ARMED : IDLE);
        SERVICED: w_state_nxt = w_pend[r_id] ? SERVICED : IDLE;
        default:  w_state_nxt = IDLE;
      endcase
  end
  assign nmi         = r_nmi_pend && !r_rst;
  assign irq         = (r_state == ARMED) && !r_rst;
  assign rst         = r_rst;
  assign irq_id      = r_id;
  assign irq_mask    = r_mask;
  assign irq_pending = r_pend;
endmodule
